bus_read_6502: RTL and testbench



---
 rtl/bus6502_pkg.sv | 34 +++
 rtl/bus_read_6502_if.sv | 24 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/bus_read_6502.sv | 131 +++++++++++++
 tb/tb_bus_read_6502.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus6502_pkg.sv
// Shared definitions for the 6502 read-side responder: register map, status
// byte layout and FSM state encoding.
package bus6502_pkg;

   localparam logic [3:0] REG_FIFO = 4'h0;
   localparam logic [3:0] REG_STAT = 4'h1;
   localparam logic [3:0] REG_RAM  = 4'h2;
   localparam logic [3:0] REG_ID   = 4'h3;

   localparam int ST_FULL  = 7;
   localparam int ST_EMPTY = 6;
   localparam int ST_OVF   = 5;
   localparam int ST_UDF   = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } state_t;

   function automatic logic [7:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic       udf,
                                              input logic [3:0] cnt);
      logic [7:0] s;
      s           = {4'b0000, cnt};
      s[ST_FULL]  = full;
      s[ST_EMPTY] = empty;
      s[ST_OVF]   = ovf;
      s[ST_UDF]   = udf;
      return s;
   endfunction

endpackage

// File: rtl/bus_read_6502_if.sv
// 6502 bus pins plus internal FIFO producer handshake; slave side is the responder.
// Internal push uses valid/ready, the 6502 side has no backpressure.
interface bus_read_6502_if;
   logic       clk_ext1;
   logic       cs;
   logic [3:0] rs;
   logic       wren;
   logic [7:0] ram_q;
   logic       push_valid;
   logic [7:0] push_data;
   logic       push_ready;
   logic [7:0] data_out;
   logic       data_oe;

   modport slave (
      input  clk_ext1, cs, rs, wren, ram_q, push_valid, push_data,
      output push_ready, data_out, data_oe
   );

   modport master (
      output clk_ext1, cs, rs, wren, ram_q, push_valid, push_data,
      input  push_ready, data_out, data_oe
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, head visible combinationally; push written cycle N readable at N+1.
// Push refused when full and pop ignored when empty; push and pop may coincide.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_push_data,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_pop_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_full,
   output logic                         o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full     = (r_count == CW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_pop_data = r_mem[r_rd_ptr];
   assign w_do_push  = i_push && !o_full;
   assign w_do_pop   = i_pop && !o_empty;

   // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/bus_read_6502.sv
// 6502 read responder: data_oe 3 clk after pin-level phi2 rise, drops 3 clk after phi2 fall/cs rise.
// FIFO push is valid/ready (ready = not full); full pushes are dropped and flagged.
module bus_read_6502
   import bus6502_pkg::*;
#(
   parameter int         FIFO_DEPTH = 8,
   parameter logic [7:0] DEV_ID     = 8'h65
) (
   input logic              clk,
   input logic              rst,
   bus_read_6502_if.slave   bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic          r_phi2_s1, r_phi2_s2, r_phi2_s3;
   logic          r_cs_s1, r_cs_s2;
   logic          r_wren_s1, r_wren_s2;

   state_t        r_state;
   logic [3:0]    r_rs;
   logic [7:0]    r_data_out;
   logic          r_data_oe;
   logic          r_lat_empty;
   logic          r_overflow;
   logic          r_underflow;

   logic          w_phi2_rise;
   logic          w_phi2_fall;
   logic          w_start;
   logic          w_exit;
   logic          w_pop;
   logic          w_set_ovf, w_set_udf, w_clr_ovf, w_clr_udf;
   logic [7:0]    w_head;
   logic [CW-1:0] w_count;
   logic [3:0]    w_count4;
   logic          w_full;
   logic          w_empty;
   logic [7:0]    w_rd_data;

   // Synchronizers stay unreset so a phi2 level held across reset is not seen as a fresh edge
   always_ff @(posedge clk) begin
      r_phi2_s1 <= bus.clk_ext1;
      r_phi2_s2 <= r_phi2_s1;
      r_phi2_s3 <= r_phi2_s2;
      r_cs_s1   <= bus.cs;
      r_cs_s2   <= r_cs_s1;
      r_wren_s1 <= bus.wren;
      r_wren_s2 <= r_wren_s1;
   end

   assign w_phi2_rise = r_phi2_s2 && !r_phi2_s3;
   assign w_phi2_fall = !r_phi2_s2 && r_phi2_s3;
   assign w_start     = (r_state == IDLE) && w_phi2_rise && !r_cs_s2 && r_wren_s2;
   assign w_exit      = (r_state == DRIVE) && (w_phi2_fall || r_cs_s2);

   assign w_pop     = w_exit && (r_rs == REG_FIFO) && !r_lat_empty;
   assign w_set_udf = w_exit && (r_rs == REG_FIFO) && r_lat_empty;
   assign w_set_ovf = bus.push_valid && w_full;
   assign w_clr_ovf = w_exit && (r_rs == REG_STAT) && r_data_out[ST_OVF];
   assign w_clr_udf = w_exit && (r_rs == REG_STAT) && r_data_out[ST_UDF];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (bus.push_valid),
      .i_push_data (bus.push_data),
      .i_pop       (w_pop),
      .o_pop_data  (w_head),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   assign w_count4 = 4'(w_count);

   always_comb begin
      w_rd_data = 8'h00;
      case (bus.rs)
         REG_FIFO: w_rd_data = w_empty ? 8'h00 : w_head;
         REG_STAT: w_rd_data = pack_status(w_full, w_empty, r_overflow, r_underflow, w_count4);
         REG_RAM:  w_rd_data = bus.ram_q;
         REG_ID:   w_rd_data = DEV_ID;
         default:  w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rs        <= 4'h0;
         r_data_out  <= 8'h00;
         r_data_oe   <= 1'b0;
         r_lat_empty <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state     <= DRIVE;
                  r_rs        <= bus.rs;
                  r_data_out  <= w_rd_data;
                  r_data_oe   <= 1'b1;
                  r_lat_empty <= w_empty;
               end
            end
            DRIVE: begin
               if (w_exit) begin
                  r_state   <= IDLE;
                  r_data_oe <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase

         // Set is applied after clear so a coincident set wins
         if (w_clr_ovf) r_overflow  <= 1'b0;
         if (w_clr_udf) r_underflow <= 1'b0;
         if (w_set_ovf) r_overflow  <= 1'b1;
         if (w_set_udf) r_underflow <= 1'b1;
      end
   end

   assign bus.data_out   = r_data_out;
   assign bus.data_oe    = r_data_oe;
   assign bus.push_ready = !w_full;

endmodule

// File: tb/tb_bus_read_6502.sv
// Bench for bus_read_6502: table of push/read/write ops with a read-data scoreboard,
// plus hand sequences for timing, overflow and reset during DRIVE.
`timescale 1ns/1ps
module tb_bus_read_6502;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   bus_read_6502_if bus();

   bus_read_6502 #(
      .FIFO_DEPTH (8),
      .DEV_ID     (8'h65)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] sb[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // Read-data monitor: pops the scoreboard when data_oe rises, checks data_out holds while driven
   logic       prev_oe = 1'b0;
   logic [7:0] drive_val = 8'h00;
   logic       stable = 1'b1;
   always @(negedge clk) begin
      if (bus.data_oe === 1'b1 && !prev_oe) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: read of 0x%02h with no expected value at %0t", bus.data_out, $time);
         end else begin
            check("read_data", bus.data_out, sb.pop_front());
         end
         drive_val = bus.data_out;
         stable    = 1'b1;
      end else if (bus.data_oe === 1'b1 && bus.data_out !== drive_val) begin
         stable = 1'b0;
      end
      if (bus.data_oe !== 1'b1 && prev_oe) check("data_out_hold", {7'b0, stable}, 8'h01);
      prev_oe = (bus.data_oe === 1'b1);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      bus.push_valid = 1'b1;
      bus.push_data  = b;
      @(negedge clk);
      bus.push_valid = 1'b0;
   endtask

   task automatic bus_cycle(input logic [3:0] rs, input logic wren,
                            output int rise_lat, output int fall_lat);
      @(negedge clk);
      bus.cs   = 1'b0;
      bus.rs   = rs;
      bus.wren = wren;
      repeat (3) @(negedge clk);
      bus.clk_ext1 = 1'b1;
      rise_lat = 0;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         if (rise_lat == 0 && bus.data_oe === 1'b1) rise_lat = i;
      end
      bus.clk_ext1 = 1'b0;
      fall_lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (fall_lat == 0 && bus.data_oe === 1'b0) fall_lat = i;
      end
      bus.cs   = 1'b1;
      bus.wren = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_read(input logic [3:0] rs, input logic [7:0] exp);
      int rl, fl;
      sb.push_back(exp);
      bus_cycle(rs, 1'b1, rl, fl);
      check("oe_rose", {7'b0, rl != 0}, 8'h01);
   endtask

   task automatic do_write(input logic [3:0] rs);
      int rl, fl;
      bus_cycle(rs, 1'b0, rl, fl);
      check("write_no_oe", {7'b0, rl != 0}, 8'h00);
   endtask

   typedef struct {
      int         kind;   // 0 push, 1 read, 2 write
      logic [3:0] rs;
      logic [7:0] dat;    // push byte or expected read value
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int k, input logic [3:0] r, input logic [7:0] d);
      vec_t v;
      v.kind = k;
      v.rs   = r;
      v.dat  = d;
      return v;
   endfunction

   initial begin
      int rl, fl;

      vecs.push_back(mk(0, 4'h0, 8'hA1));
      vecs.push_back(mk(0, 4'h0, 8'hB2));
      vecs.push_back(mk(0, 4'h0, 8'hC3));
      vecs.push_back(mk(1, 4'h0, 8'hA1));
      vecs.push_back(mk(1, 4'h0, 8'hB2));
      vecs.push_back(mk(1, 4'h0, 8'hC3));
      vecs.push_back(mk(1, 4'h1, 8'h40));
      vecs.push_back(mk(1, 4'h0, 8'h00));
      vecs.push_back(mk(1, 4'h1, 8'h50));
      vecs.push_back(mk(1, 4'h1, 8'h40));
      vecs.push_back(mk(0, 4'h0, 8'h5A));
      vecs.push_back(mk(0, 4'h0, 8'h6B));
      vecs.push_back(mk(2, 4'h0, 8'h00));
      vecs.push_back(mk(1, 4'h1, 8'h02));
      vecs.push_back(mk(1, 4'h3, 8'h65));
      vecs.push_back(mk(1, 4'hF, 8'h00));
      vecs.push_back(mk(1, 4'h2, 8'h3C));
      vecs.push_back(mk(1, 4'h4, 8'h00));

      rst            = 1'b1;
      bus.clk_ext1   = 1'b0;
      bus.cs         = 1'b1;
      bus.rs         = 4'h0;
      bus.wren       = 1'b1;
      bus.ram_q      = 8'h3C;
      bus.push_valid = 1'b0;
      bus.push_data  = 8'h00;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_data_oe", {7'b0, bus.data_oe}, 8'h00);
      check("rst_data_out", bus.data_out, 8'h00);
      check("rst_push_ready", {7'b0, bus.push_ready}, 8'h01);

      // Status read on an empty FIFO with edge-to-enable latency measured
      sb.push_back(8'h40);
      bus_cycle(4'h1, 1'b1, rl, fl);
      check("oe_rise_latency", 8'(rl), 8'd3);
      check("oe_fall_latency", 8'(fl), 8'd3);

      foreach (vecs[i]) begin
         case (vecs[i].kind)
            0:       push_byte(vecs[i].dat);
            1:       do_read(vecs[i].rs, vecs[i].dat);
            default: do_write(vecs[i].rs);
         endcase
      end

      // Reset while driving a FIFO read with 0x5A, 0x6B queued
      sb.push_back(8'h5A);
      @(negedge clk);
      bus.cs   = 1'b0;
      bus.rs   = 4'h0;
      bus.wren = 1'b1;
      repeat (3) @(negedge clk);
      bus.clk_ext1 = 1'b1;
      for (int i = 0; i < 10 && bus.data_oe !== 1'b1; i++) @(negedge clk);
      check("rst_drive_oe_up", {7'b0, bus.data_oe}, 8'h01);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_oe", {7'b0, bus.data_oe}, 8'h00);
      check("rst_mid_push_ready", {7'b0, bus.push_ready}, 8'h01);
      check("rst_mid_data_out", bus.data_out, 8'h00);
      rst = 1'b0;
      rl = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.data_oe === 1'b1) rl = i;
      end
      check("no_drive_without_edge", {7'b0, rl != 0}, 8'h00);
      bus.clk_ext1 = 1'b0;
      repeat (4) @(negedge clk);
      bus.cs = 1'b1;
      repeat (4) @(negedge clk);
      do_read(4'h1, 8'h40);

      // Fill past depth: ninth byte dropped and overflow flagged
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check("push_ready_fill", {7'b0, bus.push_ready}, (i < 8) ? 8'h01 : 8'h00);
         bus.push_valid = 1'b1;
         bus.push_data  = 8'h10 + 8'(i);
      end
      @(negedge clk);
      bus.push_valid = 1'b0;
      check("push_ready_full", {7'b0, bus.push_ready}, 8'h00);
      do_read(4'h1, 8'hA8);
      do_read(4'h1, 8'h88);
      for (int i = 0; i < 8; i++) do_read(4'h0, 8'h10 + 8'(i));
      do_read(4'h1, 8'h40);

      check("sb_drained", 8'(sb.size()), 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
